// File: rtl/regfile_pkg.sv
// Shared types, sizes and the round-robin pointer helper for the register-file write arbiter.
package regfile_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The next pointer starts at the requester after the winner, so the winner gets the lowest priority next time.
  function automatic int rr_next(input int idx, input int num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               any
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the register file write port; zero-sweeps the array after reset.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      init_done,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic [DATA_W-1:0]         rd_data1,
  output logic [DATA_W-1:0]         rd_data2,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [ADDR_W-1:0]         rf_raddr1,
  output logic [ADDR_W-1:0]         rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                init_done_q, init_done_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // init_done trails the INIT->RUN move by one edge, the same edge the last zero lands in the array.
  always_comb begin
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    we_d        = 1'b0;
    waddr_d     = '0;
    wdata_d     = '0;
    req_ready   = '0;
    init_done_d = (state_q == RUN);
    case (state_q)
      INIT: begin
        we_d       = 1'b1;
        waddr_d    = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
      end
      RUN: begin
        if (gnt_any) begin
          req_ready = gnt;
          we_d      = 1'b1;
          waddr_d   = req_addr[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d   = req_data[gnt_idx*DATA_W +: DATA_W];
          rr_ptr_d  = PTR_W'(rr_next(32'(gnt_idx), NUM_REQ));
        end
      end
      default: ;
    endcase
  end

  // A write still waiting in the output register is dropped the moment reset is seen.
  assign rf_we     = we_q & ~rst;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign init_done = init_done_q;
  assign rf_raddr1 = rd_addr1;
  assign rf_raddr2 = rd_addr2;

`ifdef REGFILE_BYPASS_EN
  logic              bp_we_q, bp_we_d;
  logic [ADDR_W-1:0] bp_waddr_q, bp_waddr_d;
  logic [DATA_W-1:0] bp_wdata_q, bp_wdata_d;
  logic [ADDR_W-1:0] bp_raddr1_q, bp_raddr1_d;
  logic [ADDR_W-1:0] bp_raddr2_q, bp_raddr2_d;

  always_comb begin
    bp_we_d     = rf_we;
    bp_waddr_d  = rf_waddr;
    bp_wdata_d  = rf_wdata;
    bp_raddr1_d = rd_addr1;
    bp_raddr2_d = rd_addr2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_we_q     <= 1'b0;
      bp_waddr_q  <= '0;
      bp_wdata_q  <= '0;
      bp_raddr1_q <= '0;
      bp_raddr2_q <= '0;
    end else begin
      bp_we_q     <= bp_we_d;
      bp_waddr_q  <= bp_waddr_d;
      bp_wdata_q  <= bp_wdata_d;
      bp_raddr1_q <= bp_raddr1_d;
      bp_raddr2_q <= bp_raddr2_d;
    end
  end

  // The array returns pre-write data for a read at the commit edge; substitute the committed value.
  assign rd_data1 = (bp_we_q && (bp_raddr1_q == bp_waddr_q)) ? bp_wdata_q : rf_rdata1;
  assign rd_data2 = (bp_we_q && (bp_raddr2_q == bp_waddr_q)) ? bp_wdata_q : rf_rdata2;
`else
  assign rd_data1 = rf_rdata1;
  assign rd_data2 = rf_rdata2;
`endif

endmodule
